// File: rtl/fix_pkg.sv
// Shared types for the fixed-point requantizer: rounding modes and pipeline depth.
package fix_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC     = 2'd0,
        RND_HALF_UP   = 2'd1,
        RND_HALF_EVEN = 2'd2,
        RND_RSVD      = 2'd3
    } rnd_mode_e;

    localparam int STAGES = 2;

endpackage

// File: rtl/fix_requant_lane.sv
// One requantizer lane: combinational shift+round (feeds stage 1) and clip (feeds stage 2).
module fix_requant_lane
    import fix_pkg::*;
#(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 32,
    parameter int SHIFT_W   = $clog2(IN_WIDTH)
) (
    input  logic [IN_WIDTH-1:0]  data_i,
    input  logic [SHIFT_W-1:0]   shift_i,
    input  rnd_mode_e            rnd_i,
    output logic [IN_WIDTH:0]    rnd_o,
    input  logic [IN_WIDTH:0]    clip_i,
    output logic [OUT_WIDTH-1:0] clip_o,
    output logic                 sat_o
);

    // Comparison width wide enough for both the rounded value and the output limits.
    localparam int WW = (IN_WIDTH + 1 > OUT_WIDTH) ? IN_WIDTH + 1 : OUT_WIDTH;
    localparam logic signed [WW-1:0] MAXV =
        $signed({{(WW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
    localparam logic signed [WW-1:0] MINV = ~MAXV;

    logic signed [IN_WIDTH:0] dext;
    logic signed [IN_WIDTH:0] quo;
    logic                     rbit;
    logic                     tbit;
    logic                     inc;
    logic signed [WW-1:0]     vx;

    assign dext = {data_i[IN_WIDTH-1], data_i};
    assign quo  = dext >>> shift_i;

    // rbit is the first bit shifted out, tbit the OR of everything below it.
    always_comb begin
        rbit = 1'b0;
        tbit = 1'b0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (i + 1 == int'(shift_i))
                rbit = data_i[i];
            else if (i + 1 < int'(shift_i))
                tbit = tbit | data_i[i];
        end
    end

    always_comb begin
        inc = 1'b0;
        case (rnd_i)
            RND_HALF_UP:   inc = rbit;
            RND_HALF_EVEN: inc = rbit && (tbit || quo[0]);
            default:       inc = 1'b0;
        endcase
    end

    assign rnd_o = quo + {{IN_WIDTH{1'b0}}, inc};

    generate
        if (WW > IN_WIDTH + 1) begin : g_ext
            assign vx = {{(WW-IN_WIDTH-1){clip_i[IN_WIDTH]}}, clip_i};
        end else begin : g_noext
            assign vx = clip_i;
        end
    endgenerate

    always_comb begin
        sat_o  = 1'b0;
        clip_o = vx[OUT_WIDTH-1:0];
        if (vx > MAXV) begin
            clip_o = MAXV[OUT_WIDTH-1:0];
            sat_o  = 1'b1;
        end else if (vx < MINV) begin
            clip_o = MINV[OUT_WIDTH-1:0];
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/fix_requant.sv
// Multi-lane requantizer: stage 1 arithmetic shift + rounding, stage 2 saturation.
// Defining FIX_REQUANT_STAT_EN adds the 32-bit saturation event counter sat_cnt.
module fix_requant
    import fix_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 32,
    parameter int SHIFT_W   = $clog2(IN_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH*IN_WIDTH-1:0]  in_data,
    input  logic [SHIFT_W-1:0]          in_shift,
    input  logic [1:0]                  in_rnd,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [NUM_CH*OUT_WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]           out_sat,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        sat_sticky,
    input  logic                        clr_sticky
`ifdef FIX_REQUANT_STAT_EN
    ,
    output logic [31:0]                 sat_cnt
`endif
);

    logic [STAGES:1]                  vld_pipe_q, vld_pipe_d;
    logic [NUM_CH-1:0][IN_WIDTH:0]    s1_data_q, s1_data_d, rnd_res;
    logic [NUM_CH-1:0][OUT_WIDTH-1:0] out_data_q, out_data_d, clip_res;
    logic [NUM_CH-1:0]                out_sat_q, out_sat_d, clip_sat;
    logic                             sticky_q, sticky_d;
    logic                             s1_adv, s2_adv, out_acc, sat_hit;
    rnd_mode_e                        rnd_mode;

    assign rnd_mode = rnd_mode_e'(in_rnd);

    // A stage moves when it is empty or its successor moves; in_ready never sees in_valid.
    assign s2_adv   = !vld_pipe_q[2] || out_ready;
    assign s1_adv   = !vld_pipe_q[1] || s2_adv;
    assign in_ready = s1_adv;
    assign out_acc  = vld_pipe_q[2] && out_ready;
    assign sat_hit  = out_acc && (|out_sat_q);

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
            fix_requant_lane #(
                .IN_WIDTH  (IN_WIDTH),
                .OUT_WIDTH (OUT_WIDTH),
                .SHIFT_W   (SHIFT_W)
            ) u_lane (
                .data_i  (in_data[k*IN_WIDTH +: IN_WIDTH]),
                .shift_i (in_shift),
                .rnd_i   (rnd_mode),
                .rnd_o   (rnd_res[k]),
                .clip_i  (s1_data_q[k]),
                .clip_o  (clip_res[k]),
                .sat_o   (clip_sat[k])
            );
        end
    endgenerate

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        s1_data_d  = s1_data_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        if (s1_adv) begin
            vld_pipe_d[1] = in_valid;
            if (in_valid)
                s1_data_d = rnd_res;
        end
        if (s2_adv) begin
            vld_pipe_d[2] = vld_pipe_q[1];
            if (vld_pipe_q[1]) begin
                out_data_d = clip_res;
                out_sat_d  = clip_sat;
            end
        end
        sticky_d = sat_hit ? 1'b1 : (clr_sticky ? 1'b0 : sticky_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            s1_data_q  <= '0;
            out_data_q <= '0;
            out_sat_q  <= '0;
            sticky_q   <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_data_q  <= s1_data_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
            sticky_q   <= sticky_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_sat    = out_sat_q;
    assign out_valid  = vld_pipe_q[2];
    assign sat_sticky = sticky_q;

`ifdef FIX_REQUANT_STAT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_sticky)
            cnt_d = '0;
        else if (sat_hit && (cnt_q != '1))
            cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign sat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fix_requant.sv
// Scoreboard bench for fix_requant (IN_WIDTH=16, OUT_WIDTH=8, NUM_CH=4) with directed vectors.
module tb_fix_requant;

    localparam int NCH = 4;
    localparam int IW  = 16;
    localparam int OW  = 8;
    localparam int SW  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH*IW-1:0] in_data;
    logic [SW-1:0]     in_shift;
    logic [1:0]        in_rnd;
    logic              in_valid;
    logic              in_ready;
    logic [NCH*OW-1:0] out_data;
    logic [NCH-1:0]    out_sat;
    logic              out_valid;
    logic              out_ready;
    logic              sat_sticky;
    logic              clr_sticky;
`ifdef FIX_REQUANT_STAT_EN
    logic [31:0]       sat_cnt;
`endif

    fix_requant #(
        .NUM_CH    (NCH),
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW),
        .SHIFT_W   (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_shift   (in_shift),
        .in_rnd     (in_rnd),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sat_sticky (sat_sticky),
        .clr_sticky (clr_sticky)
`ifdef FIX_REQUANT_STAT_EN
        ,
        .sat_cnt    (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH*OW-1:0] data;
        logic [NCH-1:0]    sat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   acc_cnt = 0;
    int   base;
    int   n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one beat; the expected result is queued at the edge that accepts it.
    task automatic send(input logic [IW-1:0] l0, input logic [IW-1:0] l1,
                        input logic [IW-1:0] l2, input logic [IW-1:0] l3,
                        input logic [SW-1:0] sh, input logic [1:0] rnd,
                        input logic [OW-1:0] e0, input logic [OW-1:0] e1,
                        input logic [OW-1:0] e2, input logic [OW-1:0] e3,
                        input logic [NCH-1:0] es);
        int   w = 0;
        exp_t e;
        in_data  = {l3, l2, l1, l0};
        in_shift = sh;
        in_rnd   = rnd;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 200 cycles");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.data = {e3, e2, e1, e0};
        e.sat  = es;
        sb.push_back(e);
        acc_cnt++;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((sb.size() != 0 || out_valid) && w < 200) begin
            step();
            w++;
        end
        if (w >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d beats still pending, expected 0", sb.size());
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat: got data 0x%0h, expected no output", out_data);
            end else begin
                mon_e = sb.pop_front();
                chk("beat_data", 64'(out_data), 64'(mon_e.data));
                chk("beat_sat", 64'(out_sat), 64'(mon_e.sat));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_data    = '0;
        in_shift   = '0;
        in_rnd     = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        clr_sticky = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_sat", 64'(out_sat), 64'd0);
        chk("rst_sticky", 64'(sat_sticky), 64'd0);
        rst_n = 1'b1;
        step();
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Non-saturating beats: half-even at shift 1 and with a nonzero tail.
        send(16'h0003, 16'h0005, 16'hFFFD, 16'h0001, 4'd1, 2'd2, 8'h02, 8'h02, 8'hFE, 8'h00, 4'b0000);
        send(16'h0029, 16'h0000, 16'h0000, 16'h0000, 4'd4, 2'd2, 8'h03, 8'h00, 8'h00, 8'h00, 4'b0000);
        drain();
        chk("sticky_no_sat", 64'(sat_sticky), 64'd0);

        send(16'h0028, 16'h0018, 16'hFFE8, 16'h7FFF, 4'd4, 2'd0, 8'h02, 8'h01, 8'hFE, 8'h7F, 4'b1000);
        send(16'h0028, 16'h0018, 16'hFFE8, 16'h7FFF, 4'd4, 2'd1, 8'h03, 8'h02, 8'hFF, 8'h7F, 4'b1000);
        send(16'h0028, 16'h0018, 16'hFFE8, 16'h7FFF, 4'd4, 2'd2, 8'h02, 8'h02, 8'hFE, 8'h7F, 4'b1000);
        send(16'h8000, 16'h0005, 16'hFF80, 16'h007F, 4'd0, 2'd0, 8'h80, 8'h05, 8'h80, 8'h7F, 4'b0001);
        send(16'h07F8, 16'hF808, 16'h0000, 16'hFFFF, 4'd4, 2'd1, 8'h7F, 8'h81, 8'h00, 8'h00, 4'b0001);
        send(16'h0028, 16'h0038, 16'h1234, 16'h8000, 4'd4, 2'd3, 8'h02, 8'h03, 8'h7F, 8'h80, 4'b1100);
        drain();
        chk("sticky_set", 64'(sat_sticky), 64'd1);
`ifdef FIX_REQUANT_STAT_EN
        chk("sat_cnt_6", 64'(sat_cnt), 64'd6);
`endif
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        chk("sticky_cleared", 64'(sat_sticky), 64'd0);
`ifdef FIX_REQUANT_STAT_EN
        chk("sat_cnt_cleared", 64'(sat_cnt), 64'd0);
`endif

        // Backpressure: only the two pipeline stages can absorb beats.
        out_ready = 1'b0;
        base = acc_cnt;
        fork
            begin
                send(16'h0028, 16'h0018, 16'hFFE8, 16'h7FFF, 4'd4, 2'd0, 8'h02, 8'h01, 8'hFE, 8'h7F, 4'b1000);
                send(16'h8000, 16'h0005, 16'hFF80, 16'h007F, 4'd0, 2'd0, 8'h80, 8'h05, 8'h80, 8'h7F, 4'b0001);
                send(16'h0003, 16'h0005, 16'hFFFD, 16'h0001, 4'd1, 2'd2, 8'h02, 8'h02, 8'hFE, 8'h00, 4'b0000);
                send(16'h0028, 16'h0018, 16'hFFE8, 16'h7FFF, 4'd4, 2'd1, 8'h03, 8'h02, 8'hFF, 8'h7F, 4'b1000);
            end
        join_none
        repeat (4) step();
        chk("bp_accepted", 64'(acc_cnt - base), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_data_held", 64'(out_data), 64'h7FFE0102);
        out_ready = 1'b1;
        n = 0;
        while (acc_cnt - base < 4 && n < 50) begin
            step();
            n++;
        end
        chk("bp_all_accepted", 64'(acc_cnt - base), 64'd4);
        drain();

        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        send(16'h0028, 16'h0018, 16'hFFE8, 16'h7FFF, 4'd4, 2'd0, 8'h02, 8'h01, 8'hFE, 8'h7F, 4'b1000);
        send(16'h0028, 16'h0018, 16'hFFE8, 16'h7FFF, 4'd4, 2'd1, 8'h03, 8'h02, 8'hFF, 8'h7F, 4'b1000);
        send(16'h0028, 16'h0018, 16'hFFE8, 16'h7FFF, 4'd4, 2'd2, 8'h02, 8'h02, 8'hFE, 8'h7F, 4'b1000);
        drain();
        chk("sticky_after_3", 64'(sat_sticky), 64'd1);
`ifdef FIX_REQUANT_STAT_EN
        chk("sat_cnt_3", 64'(sat_cnt), 64'd3);
`endif

        // Clear coinciding with a saturating output acceptance: set wins for sticky.
        out_ready = 1'b0;
        send(16'h8000, 16'h0005, 16'hFF80, 16'h007F, 4'd0, 2'd0, 8'h80, 8'h05, 8'h80, 8'h7F, 4'b0001);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("held_valid", 64'(out_valid), 64'd1);
        step();
        chk("held_stable_data", 64'(out_data), 64'h7F800580);
        chk("held_stable_sat", 64'(out_sat), 64'h1);
        clr_sticky = 1'b1;
        out_ready  = 1'b1;
        step();
        clr_sticky = 1'b0;
        chk("sticky_set_wins", 64'(sat_sticky), 64'd1);
`ifdef FIX_REQUANT_STAT_EN
        chk("sat_cnt_clear_wins", 64'(sat_cnt), 64'd0);
`endif

        // Reset with two beats in flight must discard both.
        out_ready = 1'b0;
        base = acc_cnt;
        fork
            begin
                send(16'h07F8, 16'hF808, 16'h0000, 16'hFFFF, 4'd4, 2'd1, 8'h7F, 8'h81, 8'h00, 8'h00, 4'b0001);
                send(16'h0028, 16'h0038, 16'h1234, 16'h8000, 4'd4, 2'd3, 8'h02, 8'h03, 8'h7F, 8'h80, 4'b1100);
            end
        join_none
        n = 0;
        while (acc_cnt - base < 2 && n < 20) begin
            step();
            n++;
        end
        chk("inflight_accepted", 64'(acc_cnt - base), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sticky", 64'(sat_sticky), 64'd0);
        sb.delete();
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) step();
        chk("postrst_no_output", 64'(out_valid), 64'd0);
        chk("postrst_in_ready", 64'(in_ready), 64'd1);

        send(16'h0029, 16'h0000, 16'h0000, 16'h0000, 4'd4, 2'd2, 8'h03, 8'h00, 8'h00, 8'h00, 4'b0000);
        chk("latency_not_yet", 64'(out_valid), 64'd0);
        step();
        chk("latency_valid", 64'(out_valid), 64'd1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
